// File: rtl/term_tx_scheduler.sv
// term_tx_scheduler
//   Shares the terminal's single UART transmitter between two byte sources:
//   a full-screen refresh stream and a one-byte echo requester. The refresh
//   stream is ESC [ H followed by the ROWS x COLS character buffer, row by
//   row, with CR/LF between rows (none after the last row). Each source owns
//   a 1-deep holding register, and ties are broken round-robin.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   i_refresh_req   single-cycle pulse that starts a refresh (ignored while busy)
//   o_refresh_busy  refresh in progress, clears with the last refresh strobe
//   i_echo_v        echo byte valid
//   i_echo_data     echo byte
//   o_echo_rdy      echo holding register empty
//   o_mem_en        buffer read enable (one-cycle pulse)
//   o_mem_addr      buffer read address, row*COLS + col
//   i_mem_data      buffer read data, valid the cycle after o_mem_en
//   o_tx_data       byte to the transmitter, held between strobes
//   o_tx_v          single-cycle transmit strobe
//   i_tx_busy       transmitter busy, blocks new strobes
module term_tx_scheduler #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_refresh_req,
  output logic              o_refresh_busy,
  input  logic              i_echo_v,
  input  logic [7:0]        i_echo_data,
  output logic              o_echo_rdy,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_v,
  input  logic              i_tx_busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HOME0, S_HOME1, S_HOME2, S_FETCH, S_CAPT, S_EOL_CR, S_EOL_LF
  } state_e;

  state_e            state_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              busy_q;
  logic              e_valid_q, r_valid_q, r_last_q;
  logic [7:0]        e_data_q, r_data_q;
  logic              tx_v_q;
  logic [7:0]        tx_data_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              last_echo_q;  // 1: echo was granted last, refresh wins a tie

  logic              issue_d, pick_r_d;
  logic [ADDR_W-1:0] addr_d;

  // A strobe never follows a strobe, so the transmitter sees its busy rise
  // before it can be offered another byte.
  always_comb begin
    issue_d  = !i_tx_busy && !tx_v_q && (e_valid_q || r_valid_q);
    pick_r_d = r_valid_q && (!e_valid_q || last_echo_q);
    addr_d   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      e_valid_q   <= 1'b0;
      e_data_q    <= '0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_last_q    <= 1'b0;
      tx_v_q      <= 1'b0;
      tx_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      last_echo_q <= 1'b1;
    end else begin
      tx_v_q   <= 1'b0;
      mem_en_q <= 1'b0;

      // Echo load only when empty; clearing only happens when full, so the
      // two never collide.
      if (i_echo_v && !e_valid_q) begin
        e_valid_q <= 1'b1;
        e_data_q  <= i_echo_data;
      end

      if (issue_d) begin
        tx_v_q <= 1'b1;
        if (pick_r_d) begin
          tx_data_q   <= r_data_q;
          r_valid_q   <= 1'b0;
          last_echo_q <= 1'b0;
          if (r_last_q) busy_q <= 1'b0;
        end else begin
          tx_data_q   <= e_data_q;
          e_valid_q   <= 1'b0;
          last_echo_q <= 1'b1;
        end
      end

      // Every state that loads R waits for it to be empty, so loads never
      // coincide with the transmit path clearing R.
      case (state_q)
        S_IDLE: begin
          if (i_refresh_req && !busy_q) begin
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_HOME0;
          end
        end
        S_HOME0: if (!r_valid_q) begin
          r_valid_q <= 1'b1;
          r_data_q  <= 8'h1B;
          r_last_q  <= 1'b0;
          state_q   <= S_HOME1;
        end
        S_HOME1: if (!r_valid_q) begin
          r_valid_q <= 1'b1;
          r_data_q  <= 8'h5B;
          state_q   <= S_HOME2;
        end
        S_HOME2: if (!r_valid_q) begin
          r_valid_q <= 1'b1;
          r_data_q  <= 8'h48;
          state_q   <= S_FETCH;
        end
        S_FETCH: if (!r_valid_q) begin
          mem_en_q   <= 1'b1;
          mem_addr_q <= addr_d;
          state_q    <= S_CAPT;
        end
        S_CAPT: begin
          // First CAPT cycle is the memory access cycle (mem_en_q still
          // high); read data is captured on the following edge.
          if (!mem_en_q) begin
            r_valid_q <= 1'b1;
            r_data_q  <= i_mem_data;
            if (col_q != CW'(COLS - 1)) begin
              col_q   <= col_q + 1'b1;
              state_q <= S_FETCH;
            end else if (row_q != RW'(ROWS - 1)) begin
              col_q   <= '0;
              row_q   <= row_q + 1'b1;
              state_q <= S_EOL_CR;
            end else begin
              r_last_q <= 1'b1;
              state_q  <= S_IDLE;
            end
          end
        end
        S_EOL_CR: if (!r_valid_q) begin
          r_valid_q <= 1'b1;
          r_data_q  <= 8'h0D;
          state_q   <= S_EOL_LF;
        end
        S_EOL_LF: if (!r_valid_q) begin
          r_valid_q <= 1'b1;
          r_data_q  <= 8'h0A;
          state_q   <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_refresh_busy = busy_q;
  assign o_echo_rdy     = !e_valid_q;
  assign o_mem_en       = mem_en_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_tx_data      = tx_data_q;
  assign o_tx_v         = tx_v_q;

endmodule

// File: tb/tb_term_tx_scheduler.sv
module tb_term_tx_scheduler;

  localparam int COLS   = 40;
  localparam int ROWS   = 25;
  localparam int ADDR_W = 10;
  localparam int NREF   = 3 + ROWS * COLS + 2 * (ROWS - 1);
  localparam int LIMIT  = 12000;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_refresh_req;
  logic              o_refresh_busy;
  logic              i_echo_v;
  logic [7:0]        i_echo_data;
  logic              o_echo_rdy;
  logic              o_mem_en;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        i_mem_data;
  logic [7:0]        o_tx_data;
  logic              o_tx_v;
  logic              i_tx_busy;

  always #5 clk = ~clk;

  term_tx_scheduler #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_refresh_req(i_refresh_req), .o_refresh_busy(o_refresh_busy),
    .i_echo_v(i_echo_v), .i_echo_data(i_echo_data), .o_echo_rdy(o_echo_rdy),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_tx_data(o_tx_data), .o_tx_v(o_tx_v), .i_tx_busy(i_tx_busy)
  );

  // Synchronous-read character buffer holding buffer[i] = i[7:0]
  logic [7:0] mem [0:1023];
  always @(posedge clk) if (o_mem_en) i_mem_data <= mem[o_mem_addr];

  // Strobe monitor
  logic [7:0] txq[$];
  logic [7:0] ref_q[$];
  logic       prev_v = 1'b0;
  int         adj_err = 0;
  int         mem_en_cnt = 0;
  always @(negedge clk) begin
    if (o_tx_v) begin
      txq.push_back(o_tx_data);
      if (prev_v) adj_err++;
    end
    prev_v = o_tx_v;
    if (o_mem_en) mem_en_cnt++;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    int bad = 0;
    for (int i = 0; i < ref_q.size() && i < txq.size(); i++)
      if (txq[i] !== ref_q[i]) bad++;
    check_val({tag, "_len"}, 32'(txq.size()), 32'(ref_q.size()));
    check_val({tag, "_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic pulse_refresh;
    i_refresh_req = 1'b1;
    tick;
    i_refresh_req = 1'b0;
  endtask

  task automatic wait_refresh_done(input string tag);
    int cyc = 0;
    while (o_refresh_busy && cyc < LIMIT) begin
      tick;
      cyc++;
    end
    check_val({tag, "_done"}, 32'(o_refresh_busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int sz, mem0, k, bad, idx;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    ref_q = '{8'h1B, 8'h5B, 8'h48};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) ref_q.push_back(8'(r * COLS + c));
      if (r < ROWS - 1) begin
        ref_q.push_back(8'h0D);
        ref_q.push_back(8'h0A);
      end
    end

    rst = 1'b0; i_refresh_req = 1'b0; i_echo_v = 1'b0; i_echo_data = 8'h00; i_tx_busy = 1'b0;

    // Reset and idle
    repeat (3) tick;
    rst = 1'b1;
    tick;
    check_val("rst_tx_v",    32'(o_tx_v), 32'd0);
    check_val("rst_tx_data", 32'(o_tx_data), 32'h00);
    check_val("rst_mem_en",  32'(o_mem_en), 32'd0);
    check_val("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    check_val("rst_busy",    32'(o_refresh_busy), 32'd0);
    check_val("rst_echo_rdy", 32'(o_echo_rdy), 32'd1);
    repeat (100) tick;
    check_val("idle_strobes", 32'(txq.size()), 32'd0);
    check_val("idle_mem_en",  32'(mem_en_cnt), 32'd0);
    check_val("idle_echo_rdy", 32'(o_echo_rdy), 32'd1);

    // Single echo
    i_echo_v = 1'b1; i_echo_data = 8'h41;
    tick;
    i_echo_v = 1'b0;
    check_val("echo_rdy_low", 32'(o_echo_rdy), 32'd0);
    check_val("echo_no_early_v", 32'(o_tx_v), 32'd0);
    tick;
    check_val("echo_tx_v",    32'(o_tx_v), 32'd1);
    check_val("echo_tx_data", 32'(o_tx_data), 32'h41);
    check_val("echo_rdy_back", 32'(o_echo_rdy), 32'd1);
    tick;
    check_val("echo_v_single", 32'(o_tx_v), 32'd0);
    check_val("echo_data_hold", 32'(o_tx_data), 32'h41);
    check_val("echo_count", 32'(txq.size()), 32'd1);

    // Plain refresh, with a request pulse during busy that must be ignored
    txq.delete(); adj_err = 0;
    pulse_refresh;
    check_val("rf_busy_set", 32'(o_refresh_busy), 32'd1);
    check_val("rf_v_n1", 32'(o_tx_v), 32'd0);
    tick;
    check_val("rf_v_n2", 32'(o_tx_v), 32'd0);
    tick;
    check_val("rf_first_v", 32'(o_tx_v), 32'd1);
    check_val("rf_first_data", 32'(o_tx_data), 32'h1B);
    cyc = 0;
    while (o_refresh_busy && cyc < LIMIT) begin
      tick;
      cyc++;
      i_refresh_req = (cyc == 300);
    end
    i_refresh_req = 1'b0;
    check_val("rf_done", 32'(o_refresh_busy), 32'd0);
    check_val("rf_busy_fall_v", 32'(o_tx_v), 32'd1);
    check_val("rf_busy_fall_data", 32'(o_tx_data), 32'hE7);
    repeat (10) tick;
    check_stream("rf");
    check_val("rf_adjacent", 32'(adj_err), 32'd0);

    // Refresh interleaved with a continuous echo stream of 0x55
    txq.delete(); adj_err = 0;
    i_echo_v = 1'b1; i_echo_data = 8'h55;
    repeat (6) tick;
    pulse_refresh;
    wait_refresh_done("mix");
    i_echo_v = 1'b0;
    repeat (6) tick;
    k = -1;
    for (int i = 0; i < txq.size(); i++)
      if (txq[i] == 8'h1B) begin k = i; break; end
    bad = 0;
    if (k < 0) bad = 1;
    else begin
      for (int i = 0; i < k; i++) if (txq[i] !== 8'h55) bad++;
      for (int j = 0; j < NREF; j++) begin
        idx = k + 2 * j;
        if (idx >= txq.size() || txq[idx] !== ref_q[j]) bad++;
        if (j < NREF - 1 && (idx + 1 >= txq.size() || txq[idx + 1] !== 8'h55)) bad++;
      end
      for (int i = k + 2 * NREF - 1; i < txq.size(); i++) if (txq[i] !== 8'h55) bad++;
    end
    check_val("mix_interleave", 32'(bad), 32'd0);
    check_val("mix_adjacent", 32'(adj_err), 32'd0);

    // Transmitter busy held high for 50 cycles mid-refresh
    txq.delete(); adj_err = 0;
    pulse_refresh;
    cyc = 0;
    while (txq.size() < 100 && cyc < LIMIT) begin
      tick;
      cyc++;
    end
    i_tx_busy = 1'b1;
    tick;
    sz = txq.size();
    mem0 = mem_en_cnt;
    repeat (49) tick;
    check_val("stall_no_strobe", 32'(txq.size()), 32'(sz));
    check_val("stall_mem_en_le1", 32'(mem_en_cnt - mem0 <= 1), 32'd1);
    i_tx_busy = 1'b0;
    wait_refresh_done("stall");
    repeat (10) tick;
    check_stream("stall");
    check_val("stall_adjacent", 32'(adj_err), 32'd0);

    // Reset at byte 500, then restart
    txq.delete();
    pulse_refresh;
    cyc = 0;
    while (txq.size() < 500 && cyc < LIMIT) begin
      tick;
      cyc++;
    end
    rst = 1'b0;
    #1;
    check_val("abort_tx_v",    32'(o_tx_v), 32'd0);
    check_val("abort_tx_data", 32'(o_tx_data), 32'h00);
    check_val("abort_mem_en",  32'(o_mem_en), 32'd0);
    check_val("abort_mem_addr", 32'(o_mem_addr), 32'd0);
    check_val("abort_busy",    32'(o_refresh_busy), 32'd0);
    check_val("abort_echo_rdy", 32'(o_echo_rdy), 32'd1);
    sz = txq.size();
    repeat (3) tick;
    check_val("abort_no_strobe", 32'(txq.size()), 32'(sz));
    rst = 1'b1;
    repeat (5) tick;
    check_val("abort_idle_busy", 32'(o_refresh_busy), 32'd0);
    txq.delete(); adj_err = 0;
    pulse_refresh;
    wait_refresh_done("restart");
    repeat (10) tick;
    check_stream("restart");
    check_val("restart_adjacent", 32'(adj_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
